// File: rtl/seq_alu_pkg.sv
// Shared op codes, FSM state encoding and counter-width helper for seq_alu
// and its iterative divider.
package seq_alu_pkg;

  localparam logic [4:0] OP_ADD     = 5'd0;
  localparam logic [4:0] OP_SUB     = 5'd1;
  localparam logic [4:0] OP_AND     = 5'd2;
  localparam logic [4:0] OP_OR      = 5'd3;
  localparam logic [4:0] OP_XOR     = 5'd4;
  localparam logic [4:0] OP_SLT     = 5'd5;
  localparam logic [4:0] OP_SLTU    = 5'd6;
  localparam logic [4:0] OP_UPPER   = 5'd7;
  localparam logic [4:0] OP_AUIPC   = 5'd8;
  localparam logic [4:0] OP_LUI     = 5'd9;
  localparam logic [4:0] OP_MUL     = 5'd10;
  localparam logic [4:0] OP_MULH    = 5'd11;
  localparam logic [4:0] OP_MULHSU  = 5'd12;
  localparam logic [4:0] OP_MULHU   = 5'd13;
  localparam logic [4:0] OP_DIV     = 5'd14;
  localparam logic [4:0] OP_DIVU    = 5'd15;
  localparam logic [4:0] OP_REM     = 5'd16;
  localparam logic [4:0] OP_REMU    = 5'd17;
  localparam logic [4:0] OP_INVALID = 5'd31;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_MUL  = 2'd1;
  localparam logic [1:0] ST_DIV  = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  // Iteration counter width: holds XLEN-1 down to 0.
  function automatic int cnt_width(input int xlen);
    return (xlen > 1) ? $clog2(xlen) : 1;
  endfunction

endpackage

// File: rtl/seq_alu_divider.sv
// Iterative restoring divider on unsigned magnitudes: one quotient bit per
// cycle for W cycles after start; done is high during the final step.
module seq_alu_divider
  import seq_alu_pkg::*;
#(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [W-1:0] dividend,
  input  logic [W-1:0] divisor,
  output logic         done,
  output logic [W-1:0] quotient,
  output logic [W-1:0] remainder
);

  localparam int CNT_W = cnt_width(W);

  logic             running_q, running_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [W-1:0]     quo_q, quo_d;
  logic [W-1:0]     rem_q, rem_d;
  logic [W-1:0]     den_q, den_d;

  logic [W:0]   rem_sh;
  logic [W:0]   rem_try;
  logic         fits;
  logic [W-1:0] rem_nx;
  logic [W-1:0] quo_nx;

  // Partial remainder stays below the divisor, so W bits hold it.
  always_comb begin
    rem_sh  = {rem_q, quo_q[W-1]};
    rem_try = rem_sh - {1'b0, den_q};
    fits    = ~rem_try[W];
    rem_nx  = fits ? rem_try[W-1:0] : rem_sh[W-1:0];
    quo_nx  = {quo_q[W-2:0], fits};
  end

  assign done      = running_q && (cnt_q == '0);
  assign quotient  = quo_nx;
  assign remainder = rem_nx;

  always_comb begin
    running_d = running_q;
    cnt_d     = cnt_q;
    quo_d     = quo_q;
    rem_d     = rem_q;
    den_d     = den_q;
    if (start) begin
      running_d = 1'b1;
      cnt_d     = CNT_W'(W - 1);
      quo_d     = dividend;
      rem_d     = '0;
      den_d     = divisor;
    end else if (running_q) begin
      quo_d = quo_nx;
      rem_d = rem_nx;
      cnt_d = cnt_q - 1'b1;
      if (cnt_q == '0) running_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      running_q <= 1'b0;
      cnt_q     <= '0;
      quo_q     <= '0;
      rem_q     <= '0;
      den_q     <= '0;
    end else begin
      running_q <= running_d;
      cnt_q     <= cnt_d;
      quo_q     <= quo_d;
      rem_q     <= rem_d;
      den_q     <= den_d;
    end
  end

endmodule

// File: rtl/seq_alu.sv
// Handshaked ALU with iterative RV32M multiply/divide; all outputs registered.
// Define SEQ_ALU_FAST_MUL_EN for a single-cycle combinational multiplier.
module seq_alu
  import seq_alu_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int CTRL_W = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [XLEN-1:0]   A,
  input  logic [XLEN-1:0]   B,
  input  logic [CTRL_W-1:0] ALUControl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   Result,
  output logic              Zero,
  output logic              V,
  output logic              busy,
  output logic [1:0]        dbg_state
);

  // Handshake: an op is taken on an edge with in_valid && in_ready (IDLE only);
  // the result is held while out_valid && !out_ready and retired on the edge
  // with out_valid && out_ready, after which in_ready returns the next cycle.

  localparam logic [XLEN-1:0] IMM_MASK = ~XLEN'(12'hFFF);
  localparam logic [XLEN-1:0] MIN_INT  = {1'b1, {(XLEN-1){1'b0}}};

  logic [1:0]      state_q, state_d;
  logic [4:0]      op_q, op_d;
  logic [XLEN-1:0] result_q, result_d;
  logic            v_q, v_d;
  logic            neg_q, neg_d;
  logic            rneg_q, rneg_d;

  logic [4:0]      op_in;
  logic [XLEN-1:0] sum, diff;
  logic [XLEN-1:0] base_res;
  logic            base_v;
  logic            is_mul, is_div, a_signed, b_signed, sa, sb;
  logic [XLEN-1:0] a_mag, b_mag;
  logic            div_start, div_done;
  logic [XLEN-1:0] div_q, div_r, q_fix, r_fix;

  function automatic logic [XLEN-1:0] mul_select(input logic [2*XLEN-1:0] prod,
                                                 input logic neg, input logic [4:0] op);
    logic [2*XLEN-1:0] p;
    p = neg ? -prod : prod;
    return (op == OP_MUL) ? p[XLEN-1:0] : p[2*XLEN-1:XLEN];
  endfunction

  function automatic logic is_rem(input logic [4:0] op);
    return (op == OP_REM) || (op == OP_REMU);
  endfunction

  // Codes wider than the defined set decode as unlisted.
  assign op_in = ((ALUControl >> 5) != '0) ? OP_INVALID : ALUControl[4:0];
  assign sum   = A + B;
  assign diff  = A - B;

  always_comb begin
    base_res = '0;
    base_v   = 1'b0;
    case (op_in)
      OP_ADD: begin
        base_res = sum;
        base_v   = (A[XLEN-1] == B[XLEN-1]) && (sum[XLEN-1] != A[XLEN-1]);
      end
      OP_SUB: begin
        base_res = diff;
        base_v   = (A[XLEN-1] != B[XLEN-1]) && (diff[XLEN-1] != A[XLEN-1]);
      end
      OP_AND:   base_res = A & B;
      OP_OR:    base_res = A | B;
      OP_XOR:   base_res = A ^ B;
      OP_SLT:   base_res = {{(XLEN-1){1'b0}}, ($signed(A) < $signed(B))};
      OP_SLTU:  base_res = {{(XLEN-1){1'b0}}, (A < B)};
      OP_UPPER: base_res = A & IMM_MASK;
      OP_AUIPC: base_res = A + (B & IMM_MASK);
      OP_LUI:   base_res = B & IMM_MASK;
      default:  base_res = '0;
    endcase
  end

  always_comb begin
    is_mul   = (op_in >= OP_MUL) && (op_in <= OP_MULHU);
    is_div   = (op_in >= OP_DIV) && (op_in <= OP_REMU);
    a_signed = (op_in == OP_MULH) || (op_in == OP_MULHSU) ||
               (op_in == OP_DIV)  || (op_in == OP_REM);
    b_signed = (op_in == OP_MULH) || (op_in == OP_DIV) || (op_in == OP_REM);
    sa       = a_signed & A[XLEN-1];
    sb       = b_signed & B[XLEN-1];
    a_mag    = sa ? -A : A;
    b_mag    = sb ? -B : B;
  end

  seq_alu_divider #(.W(XLEN)) u_div (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (div_start),
    .dividend  (a_mag),
    .divisor   (b_mag),
    .done      (div_done),
    .quotient  (div_q),
    .remainder (div_r)
  );

  assign q_fix = neg_q  ? -div_q : div_q;
  assign r_fix = rneg_q ? -div_r : div_r;

`ifndef SEQ_ALU_FAST_MUL_EN
  localparam int CNT_W = cnt_width(XLEN);

  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [XLEN-1:0]   mcand_q, mcand_d;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] acc_step;

  // Shift-add: {hi, multiplier} shifts right one bit per step.
  always_comb begin
    mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, mcand_q} : '0);
    acc_step = {mul_sum, acc_q[XLEN-1:1]};
  end
`endif

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    result_d  = result_q;
    v_d       = v_q;
    neg_d     = neg_q;
    rneg_d    = rneg_q;
    div_start = 1'b0;
`ifndef SEQ_ALU_FAST_MUL_EN
    cnt_d     = cnt_q;
    mcand_d   = mcand_q;
    acc_d     = acc_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          op_d   = op_in;
          v_d    = 1'b0;
          neg_d  = sa ^ sb;
          rneg_d = sa;
          if (is_mul) begin
`ifdef SEQ_ALU_FAST_MUL_EN
            result_d = mul_select({{XLEN{1'b0}}, a_mag} * {{XLEN{1'b0}}, b_mag},
                                  sa ^ sb, op_in);
            state_d  = ST_DONE;
`else
            mcand_d = a_mag;
            acc_d   = {{XLEN{1'b0}}, b_mag};
            cnt_d   = CNT_W'(XLEN - 1);
            state_d = ST_MUL;
`endif
          end else if (is_div) begin
            if (B == '0) begin
              result_d = is_rem(op_in) ? A : '1;
              state_d  = ST_DONE;
            end else if (a_signed && (A == MIN_INT) && (B == '1)) begin
              result_d = is_rem(op_in) ? '0 : MIN_INT;
              state_d  = ST_DONE;
            end else begin
              div_start = 1'b1;
              state_d   = ST_DIV;
            end
          end else begin
            result_d = base_res;
            v_d      = base_v;
            state_d  = ST_DONE;
          end
        end
      end
`ifndef SEQ_ALU_FAST_MUL_EN
      ST_MUL: begin
        acc_d = acc_step;
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == '0) begin
          result_d = mul_select(acc_step, neg_q, op_q);
          state_d  = ST_DONE;
        end
      end
`endif
      ST_DIV: begin
        if (div_done) begin
          result_d = is_rem(op_q) ? r_fix : q_fix;
          state_d  = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      op_q     <= '0;
      result_q <= '0;
      v_q      <= 1'b0;
      neg_q    <= 1'b0;
      rneg_q   <= 1'b0;
`ifndef SEQ_ALU_FAST_MUL_EN
      cnt_q    <= '0;
      mcand_q  <= '0;
      acc_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      result_q <= result_d;
      v_q      <= v_d;
      neg_q    <= neg_d;
      rneg_q   <= rneg_d;
`ifndef SEQ_ALU_FAST_MUL_EN
      cnt_q    <= cnt_d;
      mcand_q  <= mcand_d;
      acc_q    <= acc_d;
`endif
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign busy      = (state_q != ST_IDLE);
  assign dbg_state = state_q;
  assign Result    = result_q;
  assign Zero      = (result_q == '0);
  assign V         = v_q;

endmodule

// File: tb/tb_seq_alu.sv
// Self-checking bench for seq_alu: directed cases, backpressure, mid-op reset
// and randomized ops against an arithmetic reference model.
module tb_seq_alu;

  localparam int XLEN = 32;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [XLEN-1:0] A = '0;
  logic [XLEN-1:0] B = '0;
  logic [4:0]      ALUControl = '0;
  logic            out_valid;
  logic            out_ready = 1'b1;
  logic [XLEN-1:0] Result;
  logic            Zero;
  logic            V;
  logic            busy;
  logic [1:0]      dbg_state;

  int n_checks = 0;
  int n_fail   = 0;
  logic [XLEN-1:0] exp_q[$];

  seq_alu #(.XLEN(XLEN), .CTRL_W(5)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .A          (A),
    .B          (B),
    .ALUControl (ALUControl),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .Result     (Result),
    .Zero       (Zero),
    .V          (V),
    .busy       (busy),
    .dbg_state  (dbg_state)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference model: returns {V, Result} from plain signed/unsigned arithmetic.
  function automatic logic [32:0] model(input logic [4:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
    longint    sa, sb, ua, ub, r;
    logic [63:0] p;
    logic [31:0] res;
    logic        v;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'(a);
    ub = longint'(b);
    res = '0;
    v   = 1'b0;
    case (op)
      5'd0: begin r = sa + sb; res = r[31:0]; v = (r > 64'sh7FFF_FFFF) || (r < -64'sh8000_0000); end
      5'd1: begin r = sa - sb; res = r[31:0]; v = (r > 64'sh7FFF_FFFF) || (r < -64'sh8000_0000); end
      5'd2: res = a & b;
      5'd3: res = a | b;
      5'd4: res = a ^ b;
      5'd5: res = (sa < sb) ? 32'd1 : 32'd0;
      5'd6: res = (ua < ub) ? 32'd1 : 32'd0;
      5'd7: res = a & 32'hFFFF_F000;
      5'd8: res = a + (b & 32'hFFFF_F000);
      5'd9: res = b & 32'hFFFF_F000;
      5'd10: begin p = 64'(ua * ub); res = p[31:0]; end
      5'd11: begin p = 64'(sa * sb); res = p[63:32]; end
      5'd12: begin p = 64'(sa * ub); res = p[63:32]; end
      5'd13: begin p = {32'b0, a} * {32'b0, b}; res = p[63:32]; end
      5'd14: begin
        if (b == 0) res = 32'hFFFF_FFFF;
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) res = a;
        else res = 32'($signed(a) / $signed(b));
      end
      5'd15: res = (b == 0) ? 32'hFFFF_FFFF : a / b;
      5'd16: begin
        if (b == 0) res = a;
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) res = 0;
        else res = 32'($signed(a) % $signed(b));
      end
      5'd17: res = (b == 0) ? a : a % b;
      default: res = '0;
    endcase
    return {v, res};
  endfunction

  function automatic int exp_lat(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    if (op >= 5'd10 && op <= 5'd13) begin
`ifdef SEQ_ALU_FAST_MUL_EN
      return 1;
`else
      return XLEN + 1;
`endif
    end
    if (op >= 5'd14 && op <= 5'd17) begin
      if (b == 0) return 1;
      if ((op == 5'd14 || op == 5'd16) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
      return XLEN + 1;
    end
    return 1;
  endfunction

  // Called just after a rising edge; returns just after the consuming edge.
  task automatic run_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int hold);
    logic [32:0] m;
    logic [31:0] exp_r;
    int lat;
    int n;
    m = model(op, a, b);
    exp_q.push_back(m[31:0]);
    n = 0;
    while (!in_ready && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check("in_ready_before_accept", in_ready, 1);
    out_ready  = (hold == 0);
    A          = a;
    B          = b;
    ALUControl = op;
    in_valid   = 1'b1;
    @(posedge clk); #1;
    in_valid   = 1'b0;
    A          = $urandom;
    B          = $urandom;
    ALUControl = 5'($urandom);
    lat = 1;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    exp_r = exp_q.pop_front();
    check("latency", 64'(lat), 64'(exp_lat(op, a, b)));
    check("result", Result, exp_r);
    check("zero", Zero, exp_r == 0);
    check("v", V, m[32]);
    check("busy_done", busy, 1);
    check("in_ready_done", in_ready, 0);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check("hold_valid", out_valid, 1);
      check("hold_result", Result, exp_r);
      check("hold_in_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("consumed_valid", out_valid, 0);
    check("consumed_in_ready", in_ready, 1);
  endtask

  initial begin
    logic [4:0]  r_op;
    logic [31:0] r_a, r_b;
    int stale;

    #1;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_result", Result, 0);
    check("rst_zero", Zero, 1);
    check("rst_v", V, 0);
    check("rst_busy", busy, 0);
    check("rst_state", dbg_state, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_op(5'd0,  32'h7FFF_FFFF, 32'h0000_0001, 0);
    run_op(5'd1,  32'd5, 32'd5, 0);
    run_op(5'd1,  32'h8000_0000, 32'd1, 0);
    run_op(5'd5,  32'hFFFF_FFFF, 32'd1, 0);
    run_op(5'd6,  32'hFFFF_FFFF, 32'd1, 0);
    run_op(5'd8,  32'h0000_1000, 32'h1234_5678, 0);
    run_op(5'd9,  32'd0, 32'hABCD_EFFF, 0);
    run_op(5'd11, 32'hFFFF_FFFF, 32'h0000_0002, 0);
    run_op(5'd13, 32'hFFFF_FFFF, 32'h0000_0002, 0);
    run_op(5'd10, 32'hFFFF_FFFF, 32'h0000_0002, 0);
    run_op(5'd12, 32'hFFFF_FFFF, 32'h0000_0002, 0);
    run_op(5'd14, 32'hFFFF_FFF9, 32'd2, 0);
    run_op(5'd16, 32'hFFFF_FFF9, 32'd2, 0);
    run_op(5'd15, 32'd100, 32'd7, 0);
    run_op(5'd17, 32'd100, 32'd7, 0);
    run_op(5'd14, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    run_op(5'd16, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    run_op(5'd15, 32'd9, 32'd0, 0);
    run_op(5'd16, 32'd9, 32'd0, 0);
    run_op(5'd20, 32'd3, 32'd4, 0);
    run_op(5'd0,  32'h1234_5678, 32'h1111_1111, 5);
    run_op(5'd14, 32'd1000, 32'hFFFF_FFFD, 3);

    // Reset in the middle of a divide.
    A = 32'hFFFF_FFF9; B = 32'd2; ALUControl = 5'd14; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (9) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_in_ready", in_ready, 1);
    check("midrst_busy", busy, 0);
    check("midrst_result", Result, 0);
    check("midrst_zero", Zero, 1);
    @(negedge clk);
    rst_n = 1'b1;
    check("midrst_in_ready_next", in_ready, 1);
    stale = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (out_valid) stale++;
    end
    check("midrst_no_stale", 64'(stale), 0);
    run_op(5'd17, 32'd100, 32'd7, 0);

    for (int k = 0; k < 60; k++) begin
      r_op = ($urandom_range(0, 9) == 0) ? 5'($urandom_range(18, 31)) : 5'($urandom_range(0, 17));
      r_a  = $urandom;
      r_b  = $urandom;
      case ($urandom_range(0, 5))
        0: r_b = 32'd0;
        1: begin r_a = 32'h8000_0000; r_b = 32'hFFFF_FFFF; end
        2: begin r_a = 32'($urandom_range(0, 50)); r_b = 32'($urandom_range(0, 9)); end
        default: ;
      endcase
      run_op(r_op, r_a, r_b, $urandom_range(0, 2));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
